// File: rtl/oam_update_ctrl.sv
// OAM update controller: round-robin arbitration of sprite-entry writes, with an
// optional tear-free shadow/commit scheme enabled by defining OAM_SHADOW_EN.
module oam_update_ctrl #(
  parameter int OAM_WIDTH = 32,
  parameter int OAM_DEPTH = 8,
  parameter int N_REQ     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic [2:0]                 oam_addr,
  output logic [OAM_WIDTH-1:0]       oam_data,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*3-1:0]         req_idx,
  input  logic [N_REQ*OAM_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       busy,
  output logic                       commit_done
);
  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [OAM_WIDTH-1:0] live [OAM_DEPTH];
  logic [RR_W-1:0]      rr, gnt_sel;
  logic                 gnt_any, can_grant, wr_en;
  logic [2:0]           wr_idx;
  logic [OAM_WIDTH-1:0] wr_data;
  int                   cand;

  // Round-robin pick: first valid requester at or after rr, wrapping.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_sel   = rr;
    cand      = 0;
    req_ready = '0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = (int'(rr) + o) % N_REQ;
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_sel = RR_W'(cand);
      end
    end
    wr_en = gnt_any && can_grant;
    if (wr_en) req_ready[gnt_sel] = 1'b1;
  end

  assign wr_idx  = req_idx[int'(gnt_sel)*3 +: 3];
  assign wr_data = req_data[int'(gnt_sel)*OAM_WIDTH +: OAM_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= '0;
    end else if (wr_en) begin
      if (int'(gnt_sel) == N_REQ-1) rr <= '0;
      else                          rr <= gnt_sel + 1'b1;
    end
  end

`ifdef OAM_SHADOW_EN
  typedef enum logic {IDLE, COPY} state_t;
  localparam logic [2:0] LAST = 3'(OAM_DEPTH-1);

  state_t               state, state_nxt;
  logic [OAM_WIDTH-1:0] shadow [OAM_DEPTH];
  logic                 dirty, dirty_nxt, done_nxt;
  logic [2:0]           cnt, cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dirty       <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dirty       <= dirty_nxt;
      commit_done <= done_nxt;
    end
  end

  // A write accepted on the same edge as frame_tick counts as dirty for that commit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dirty_nxt = dirty | wr_en;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          if (dirty || wr_en) begin
            state_nxt = COPY;
            cnt_nxt   = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      COPY: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          dirty_nxt = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign can_grant = !reset && (state == IDLE);
  assign busy      = (state == COPY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OAM_DEPTH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (wr_en)           shadow[wr_idx] <= wr_data;
      if (state == COPY)   live[cnt]      <= shadow[cnt];
    end
  end
`else
  assign can_grant = !reset;
  assign busy      = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_done <= 1'b0;
      for (int i = 0; i < OAM_DEPTH; i++) live[i] <= '0;
    end else begin
      commit_done <= frame_tick;
      if (wr_en) live[wr_idx] <= wr_data;
    end
  end
`endif

  // Read port: registered, so a same-cycle copy of entry k still returns the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) oam_data <= '0;
    else       oam_data <= live[oam_addr];
  end
endmodule

// File: tb/tb_oam_update_ctrl.sv
// Directed bench for oam_update_ctrl with a scoreboard for grants and reads;
// covers both builds (OAM_SHADOW_EN defined or not).
module tb_oam_update_ctrl;
  localparam int W = 32, D = 8, N = 3;
`ifdef OAM_SHADOW_EN
  localparam int CLEN = 8;
`else
  localparam int CLEN = 0;
`endif

  logic           clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
  logic [2:0]     oam_addr = '0;
  logic [W-1:0]   oam_data;
  logic [N-1:0]   req_valid = '0, req_ready;
  logic [N*3-1:0] req_idx = '0;
  logic [N*W-1:0] req_data = '0;
  logic           busy, commit_done;

  int           total = 0, bad = 0;
  int           m_rr = 0;
  logic [W-1:0] m_live [D];
  logic [W-1:0] m_shadow [D];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] gnt_q [$];

  oam_update_ctrl #(.OAM_WIDTH(W), .OAM_DEPTH(D), .N_REQ(N)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .oam_addr(oam_addr),
    .oam_data(oam_data), .req_valid(req_valid), .req_idx(req_idx),
    .req_data(req_data), .req_ready(req_ready), .busy(busy),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] idx, input logic [W-1:0] d);
    req_idx[i*3 +: 3] = idx;
    req_data[i*W +: W] = d;
  endtask

  task automatic model_commit();
`ifdef OAM_SHADOW_EN
    for (int i = 0; i < D; i++) m_live[i] = m_shadow[i];
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_live[i]   = '0;
      m_shadow[i] = '0;
    end
    m_rr = 0;
  endtask

  // Drive one request cycle; expected grant comes from the round-robin model.
  task automatic req_cycle(input string tag, input logic [N-1:0] v);
    logic [N-1:0] g = '0;
    int           c = 0;
    logic [2:0]   ix;
    req_valid = v;
    for (int o = 0; o < N; o++) begin
      int k = (m_rr + o) % N;
      if (g == '0 && v[k]) begin
        g[k] = 1'b1;
        c    = k;
      end
    end
    gnt_q.push_back(g);
    #1;
    check(tag, W'(req_ready), W'(gnt_q.pop_front()));
    if (g != '0) begin
      ix = req_idx[c*3 +: 3];
`ifdef OAM_SHADOW_EN
      m_shadow[ix] = req_data[c*W +: W];
`else
      m_live[ix] = req_data[c*W +: W];
`endif
      m_rr = (c + 1) % N;
    end
    tick();
    req_valid = '0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a);
    oam_addr = a;
    exp_q.push_back(m_live[a]);
    tick();
    check(tag, oam_data, exp_q.pop_front());
  endtask

  // Called just after the frame_tick edge; waits out any copy with a bound.
  task automatic commit_wait(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_len"}, W'(n), W'(CLEN));
    check({tag, "_done"}, W'(commit_done), W'(1));
    model_commit();
  endtask

  initial begin
    model_clear();
    req_valid = '1;
    tick();
    check("rst_ready", W'(req_ready), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(commit_done), '0);
    check("rst_data", oam_data, '0);
    reset = 1'b0;
    req_valid = '0;
    for (int a = 0; a < D; a++) read_chk("rst_read", 3'(a));

    // Three requesters hammering entry 2: grants rotate 0,1,2 and the last write wins.
    for (int i = 0; i < N; i++) set_req(i, 3'd2, 32'hA000_0000 + W'(i));
    repeat (3) req_cycle("arb_rr", 3'b111);
    read_chk("arb_idx2", 3'd2);
    set_req(1, 3'd3, 32'h0000_3333);
    set_req(0, 3'd4, 32'h0000_4444);
    req_cycle("arb_110", 3'b110);
    req_cycle("arb_011", 3'b011);
    req_cycle("arb_none", 3'b000);
    read_chk("arb_idx3", 3'd3);
    read_chk("arb_idx4", 3'd4);

    // Single write to entry 1, then a frame commit.
    set_req(0, 3'd1, 32'h1000_0105);
    req_cycle("w1_grant", 3'b001);
    read_chk("w1_pre", 3'd1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
`ifdef OAM_SHADOW_EN
    for (int k = 0; k < 8; k++) begin
      check("copy_busy", W'(busy), W'(1));
      check("copy_nodone", W'(commit_done), '0);
      tick();
    end
    check("copy_end_busy", W'(busy), '0);
    check("copy_end_done", W'(commit_done), W'(1));
    model_commit();
`else
    check("ft_busy", W'(busy), '0);
    check("ft_done", W'(commit_done), W'(1));
`endif
    tick();
    check("done_pulse", W'(commit_done), '0);
    read_chk("w1_post", 3'd1);
    read_chk("w2_post", 3'd2);

    // frame_tick while a requester waits.
    set_req(0, 3'd5, 32'h0000_5555);
    req_cycle("w5_grant", 3'b001);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    set_req(0, 3'd7, 32'h0000_7777);
    req_valid = 3'b001;
`ifdef OAM_SHADOW_EN
    for (int k = 0; k < 8; k++) begin
      frame_tick = (k == 3);
      #1;
      check("copy_ready", W'(req_ready), '0);
      check("copy_busy2", W'(busy), W'(1));
      tick();
    end
    frame_tick = 1'b0;
    check("copy2_done", W'(commit_done), W'(1));
    model_commit();
`else
    check("ft2_done", W'(commit_done), W'(1));
`endif
    req_cycle("after_copy", 3'b001);
    check("no_requeue_busy", W'(busy), '0);
    check("no_requeue_done", W'(commit_done), '0);
    tick();
    check("no_requeue_busy2", W'(busy), '0);

    // Flush pending writes, then a write coinciding with frame_tick.
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    commit_wait("flush");
    tick();
    set_req(0, 3'd6, 32'h1600_0066);
    frame_tick = 1'b1;
    req_cycle("w6_grant", 3'b001);
    frame_tick = 1'b0;
    commit_wait("w6_commit");
    read_chk("w6_post", 3'd6);
    read_chk("w7_post", 3'd7);

    // Reset in the middle of a copy (counter at 4).
    set_req(0, 3'd0, 32'h1000_00F0);
    req_cycle("w0_grant", 3'b001);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    repeat (4) tick();
    req_valid = 3'b111;
    reset = 1'b1;
    #1;
    check("mid_rst_data", oam_data, '0);
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_ready", W'(req_ready), '0);
    check("mid_rst_done", W'(commit_done), '0);
    model_clear();
    tick();
    reset = 1'b0;
    req_valid = '0;
    check("post_rst_done", W'(commit_done), '0);
    read_chk("post_rst_idx0", 3'd0);
    read_chk("post_rst_idx6", 3'd6);
    req_cycle("post_rst_rr", 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
